mult_sequencer: RTL

- FSM controller that sequences the 4-bit accumulator/Q register datapath to perform unsigned 4x4 shift-and-add multiplication.
- Drives every datapath control input: mux2x1_1_select, Acc_ps, Acc_dir, Q_dir, alu_control, data, mux4x1_select.
- The 8-bit product is left in {Acc,Q}; the datapath owns the carry into Acc MSB.
- Sits between a requester (start/busy/done handshake) and the datapath.

---
 rtl/mult_sequencer_if.sv | 37 +++
 rtl/mult_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mult_sequencer_if.sv
// =============================================================================
// Module   : mult_sequencer_if
// Purpose  : Requester handshake plus datapath control bundle for mult_sequencer.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

interface mult_sequencer_if;
    logic       start;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       busy;
    logic       done;
    logic       mux2x1_1_select;
    logic       Acc_ps;
    logic       Acc_dir;
    logic       Q_dir;
    logic [2:0] alu_control;
    logic [3:0] data;
    logic [1:0] mux4x1_select;

    // Requester / observer side.
    modport master (
        output start, op_a, op_b,
        input  busy, done, mux2x1_1_select, Acc_ps, Acc_dir, Q_dir,
               alu_control, data, mux4x1_select
    );

    // Sequencer side.
    modport slave (
        input  start, op_a, op_b,
        output busy, done, mux2x1_1_select, Acc_ps, Acc_dir, Q_dir,
               alu_control, data, mux4x1_select
    );
endinterface

`default_nettype wire

// File: rtl/mult_sequencer.sv
// =============================================================================
// Module   : mult_sequencer
// Purpose  : Shift-and-add 4x4 multiply controller for the Acc/Q datapath.
//            Optional macro MULT_SEQUENCER_SKIP_ZERO_ADD_EN bypasses ADD for 0 bits.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module mult_sequencer #(
    parameter logic [2:0] ALU_ADD  = 3'b010,
    parameter logic [2:0] ALU_PASS = 3'b000,
    parameter int         N_BITS   = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mult_sequencer_if.slave  bus
);

    localparam logic [1:0] c_LAST_ITER = 2'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_M = 3'd1,
        S_LOAD_Q = 3'd2,
        S_CLR_A  = 3'd3,
        S_ADD    = 3'd4,
        S_SHIFT  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_a;
    logic [3:0] r_mult;
    logic [1:0] r_count;
    logic       w_last_iter;

    assign w_last_iter = (r_count == c_LAST_ITER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= 4'd0;
            r_mult  <= 4'd0;
            r_count <= 2'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && bus.start) begin
                r_a     <= bus.op_a;
                r_mult  <= bus.op_b;
                r_count <= 2'd0;
            end else if (r_state == S_SHIFT) begin
                // Shadow multiplier tracks Q so bit 0 is always the current bit.
                r_mult  <= {1'b0, r_mult[3:1]};
                r_count <= r_count + 2'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next_state = S_LOAD_M;
            S_LOAD_M: w_next_state = S_LOAD_Q;
            S_LOAD_Q: w_next_state = S_CLR_A;
`ifdef MULT_SEQUENCER_SKIP_ZERO_ADD_EN
            S_CLR_A:  w_next_state = r_mult[0] ? S_ADD : S_SHIFT;
`else
            S_CLR_A:  w_next_state = S_ADD;
`endif
            S_ADD:    w_next_state = S_SHIFT;
            S_SHIFT: begin
                if (w_last_iter) begin
                    w_next_state = S_DONE;
                end else begin
`ifdef MULT_SEQUENCER_SKIP_ZERO_ADD_EN
                    // r_mult[1] becomes bit 0 after this shift.
                    w_next_state = r_mult[1] ? S_ADD : S_SHIFT;
`else
                    w_next_state = S_ADD;
`endif
                end
            end
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy            = (r_state != S_IDLE);
        bus.done            = 1'b0;
        bus.mux2x1_1_select = 1'b0;
        bus.Acc_ps          = 1'b1;
        bus.Acc_dir         = 1'b0;
        bus.Q_dir           = 1'b0;
        bus.alu_control     = ALU_PASS;
        bus.data            = 4'd0;
        bus.mux4x1_select   = 2'b11;
        case (r_state)
            S_LOAD_M: begin
                bus.data          = r_a;
                bus.mux4x1_select = 2'b10;
            end
            S_LOAD_Q: begin
                bus.data          = r_mult;
                bus.mux4x1_select = 2'b01;
            end
            S_CLR_A: begin
                bus.mux4x1_select = 2'b00;
            end
            S_ADD: begin
                bus.mux2x1_1_select = 1'b1;
                bus.mux4x1_select   = 2'b00;
                bus.alu_control     = r_mult[0] ? ALU_ADD : ALU_PASS;
            end
            S_SHIFT: begin
                bus.Acc_ps  = 1'b0;
                bus.Acc_dir = 1'b1;
                bus.Q_dir   = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
